// File: rtl/scroll_sequencer_pkg.sv
// Shared types and constants for the scrolling 7-segment message sequencer.
// The character codes match the seven_seg_display encoding.
package scroll_sequencer_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int CHAR_W     = 3;

    localparam logic [CHAR_W-1:0] BLANK = 3'b111;
    localparam logic [CHAR_W-1:0] CH_L  = 3'd0;
    localparam logic [CHAR_W-1:0] CH_E  = 3'd1;
    localparam logic [CHAR_W-1:0] CH_A  = 3'd2;
    localparam logic [CHAR_W-1:0] CH_F  = 3'd3;
    localparam logic [CHAR_W-1:0] CH_6  = 3'd4;
    localparam logic [CHAR_W-1:0] CH_7  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_sequencer_tick_prescaler.sv
// Divides the tick_in strobe by 2^speed_sel and flags the tick that should step the scroll.
module tick_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       tick_in,
    input  logic       clear,
    input  logic [1:0] speed_sel,
    output logic       step
);

    logic [2:0] count;
    logic [2:0] limit;

    // >= rather than == so a speed change that lowers the limit below count
    // still steps on the next tick instead of waiting for a counter wrap.
    assign limit = 3'((4'd1 << speed_sel) - 4'd1);
    assign step  = enable && tick_in && (count >= limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (enable && tick_in) begin
            count <= step ? 3'd0 : count + 3'd1;
        end
    end

endmodule

// File: rtl/scroll_sequencer.sv
// Holds a message of character codes and rotates it left or right across the
// digit positions at a rate derived from tick_in.
module scroll_sequencer
    import scroll_sequencer_pkg::state_t,
           scroll_sequencer_pkg::IDLE,
           scroll_sequencer_pkg::HOLD,
           scroll_sequencer_pkg::RUN,
           scroll_sequencer_pkg::BLANK;
#(
    parameter int NUM_DIGITS = scroll_sequencer_pkg::NUM_DIGITS,
    parameter int CHAR_W     = scroll_sequencer_pkg::CHAR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         tick_in,
    input  logic                         run,
    input  logic                         dir,
    input  logic [1:0]                   speed_sel,
    input  logic                         load_valid,
    input  logic [NUM_DIGITS*CHAR_W-1:0] load_data,
    output logic                         load_ready,
    output logic [NUM_DIGITS*CHAR_W-1:0] chars,
    output logic [2:0]                   offset,
    output logic                         running,
    output logic                         wrap,
    output state_t                       state_dbg
);

    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

    state_t                       state;
    logic [NUM_DIGITS*CHAR_W-1:0] msg;
    logic                         accept;
    logic                         step;
    logic                         presc_clear;

    // A message is taken when load_valid meets load_ready; RUN never accepts.
    assign load_ready  = (state != RUN);
    assign accept      = load_valid && load_ready;
    assign presc_clear = accept || (state != RUN);
    assign state_dbg   = state;

    tick_prescaler u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .enable    ((state == RUN) && run),
        .tick_in   (tick_in),
        .clear     (presc_clear),
        .speed_sel (speed_sel),
        .step      (step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            msg     <= {NUM_DIGITS{BLANK}};
            offset  <= 3'd0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        msg    <= load_data;
                        offset <= 3'd0;
                        state  <= HOLD;
                    end else if (state == HOLD && run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    // Dropping run wins over a coincident step.
                    if (!run) begin
                        state   <= HOLD;
                        running <= 1'b0;
                    end else if (step) begin
                        if (!dir) begin
                            offset <= (offset == LAST) ? 3'd0 : offset + 3'd1;
                            wrap   <= (offset == LAST);
                        end else begin
                            offset <= (offset == 3'd0) ? LAST : offset - 3'd1;
                            wrap   <= (offset == 3'd0);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Position p shows message digit (p + offset) mod NUM_DIGITS; digit 0 sits in the MSBs.
    always_comb begin
        int idx;
        idx   = 0;
        chars = {NUM_DIGITS{BLANK}};
        if (state != IDLE) begin
            for (int p = 0; p < NUM_DIGITS; p++) begin
                idx = p + int'(offset);
                if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
                chars[(NUM_DIGITS-1-p)*CHAR_W +: CHAR_W] = msg[(NUM_DIGITS-1-idx)*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed bench for scroll_sequencer: load, left/right scroll, prescaling,
// load blocking while running, and asynchronous reset mid-run.
module tb_scroll_sequencer;
    import scroll_sequencer_pkg::*;

    logic         clk;
    logic         reset;
    logic         tick_in;
    logic         run;
    logic         dir;
    logic [1:0]   speed_sel;
    logic         load_valid;
    logic [17:0]  load_data;
    logic         load_ready;
    logic [17:0]  chars;
    logic [2:0]   offset;
    logic         running;
    logic         wrap;
    state_t       state_dbg;

    int checks   = 0;
    int failures = 0;

    scroll_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .tick_in    (tick_in),
        .run        (run),
        .dir        (dir),
        .speed_sel  (speed_sel),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .chars      (chars),
        .offset     (offset),
        .running    (running),
        .wrap       (wrap),
        .state_dbg  (state_dbg)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    // One-cycle tick; returns at the following negedge with outputs settled.
    task automatic tick_pulse();
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; tick_in = 1'b0; run = 1'b0; dir = 1'b0; speed_sel = 2'd0;
        load_valid = 1'b0; load_data = '0;
        #12;
        chk("rst_chars", 32'(chars), 32'o777777);
        chk("rst_offset", 32'(offset), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_ready", 32'(load_ready), 1);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk); reset = 1'b0;
        @(negedge clk);

        // load 012345
        load_valid = 1'b1; load_data = 18'o012345;
        #1 chk("load_ready_accept", 32'(load_ready), 1);
        @(negedge clk); load_valid = 1'b0;
        chk("load_state", 32'(state_dbg), 32'(HOLD));
        chk("load_chars", 32'(chars), 32'o012345);
        chk("load_offset", 32'(offset), 0);

        // scroll left, speed 1
        run = 1'b1;
        @(negedge clk);
        chk("run_state", 32'(state_dbg), 32'(RUN));
        chk("run_running", 32'(running), 1);
        tick_pulse();
        chk("left1_chars", 32'(chars), 32'o123450);
        chk("left1_offset", 32'(offset), 1);
        chk("left1_wrap", 32'(wrap), 0);
        for (int k = 2; k <= 6; k++) begin
            tick_pulse();
            chk("left_wrap", 32'(wrap), (k == 6) ? 1 : 0);
        end
        chk("left6_chars", 32'(chars), 32'o012345);
        chk("left6_offset", 32'(offset), 0);
        idle_cycle();
        chk("wrap_one_cycle", 32'(wrap), 0);

        // speed 4 ticks per step
        speed_sel = 2'd2;
        for (int k = 0; k < 3; k++) begin
            tick_pulse();
            chk("div4_nostep", 32'(offset), 0);
        end
        tick_pulse();
        chk("div4_step", 32'(offset), 1);
        chk("div4_chars", 32'(chars), 32'o123450);
        for (int k = 0; k < 3; k++) tick_pulse();
        chk("div4_pre", 32'(offset), 1);
        tick_in = 1'b1; run = 1'b0;
        @(negedge clk); tick_in = 1'b0;
        chk("drop_offset", 32'(offset), 1);
        chk("drop_running", 32'(running), 0);
        chk("drop_state", 32'(state_dbg), 32'(HOLD));
        chk("drop_chars", 32'(chars), 32'o123450);

        // reload in HOLD resets offset, then one right step
        load_valid = 1'b1; load_data = 18'o012345;
        @(negedge clk); load_valid = 1'b0;
        chk("reload_offset", 32'(offset), 0);
        speed_sel = 2'd0; dir = 1'b1; run = 1'b1;
        @(negedge clk);
        tick_pulse();
        chk("right_chars", 32'(chars), 32'o501234);
        chk("right_offset", 32'(offset), 5);
        chk("right_wrap", 32'(wrap), 1);
        idle_cycle();
        chk("right_wrap_clear", 32'(wrap), 0);

        // load attempt while running is refused
        load_valid = 1'b1; load_data = 18'o543210;
        #1 chk("run_ready", 32'(load_ready), 0);
        @(negedge clk);
        chk("run_load_chars", 32'(chars), 32'o501234);
        run = 1'b0;
        @(negedge clk);
        chk("hold_state", 32'(state_dbg), 32'(HOLD));
        chk("hold_chars_pre", 32'(chars), 32'o501234);
        @(negedge clk); load_valid = 1'b0;
        chk("late_load_chars", 32'(chars), 32'o543210);
        chk("late_load_offset", 32'(offset), 0);

        // scroll to offset 3, then reset mid-run
        dir = 1'b0; run = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick_pulse();
        chk("pre_rst_offset", 32'(offset), 3);
        chk("pre_rst_chars", 32'(chars), 32'o210543);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_chars", 32'(chars), 32'o777777);
        chk("mid_rst_offset", 32'(offset), 0);
        chk("mid_rst_running", 32'(running), 0);
        chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        tick_pulse();
        tick_pulse();
        chk("post_rst_state", 32'(state_dbg), 32'(IDLE));
        chk("post_rst_chars", 32'(chars), 32'o777777);
        chk("post_rst_running", 32'(running), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
